// File: rtl/game_vga_pkg.sv
// Shared screen geometry, colour constants and scheduler types for the
// game's VGA write path.
package game_vga_pkg;
   localparam int H_RES_DEF = 320;
   localparam int V_RES_DEF = 240;
   localparam int X_W       = 9;
   localparam int Y_W       = 8;
   localparam int COL_W     = 3;

   localparam logic [COL_W-1:0] BLACK = 3'b000;
   localparam logic [COL_W-1:0] WHITE = 3'b111;

   typedef enum logic [1:0] {IDLE, SWEEP, NOTE_WAIT, NOTE_DRAW} state_e;

   typedef struct packed {
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [COL_W-1:0] colour;
   } note_req_t;

   // One adapter write; from_bg selects the painter colour that arrives
   // one cycle after the query instead of a stored colour.
   typedef struct packed {
      logic             plot;
      logic             from_bg;
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [COL_W-1:0] colour;
   } pix_t;

   // Coordinates carry one spare bit so note overhang is caught, not wrapped.
   function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py,
                                      input int h_res, input int v_res);
      return (int'(px) < h_res) && (int'(py) < v_res);
   endfunction
endpackage

// File: rtl/lane_frame_scheduler_if.sv
// Note request channel plus the vga_adapter write bus driven by the scheduler.
interface lane_frame_scheduler_if;
   import game_vga_pkg::*;

   logic             note_valid;
   logic             note_ready;
   logic [X_W-1:0]   note_x;
   logic [Y_W-1:0]   note_y;
   logic [COL_W-1:0] note_colour;

   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [COL_W-1:0] colour;
   logic             plot;

   modport master (
      input  note_valid, note_x, note_y, note_colour,
      output note_ready, x, y, colour, plot
   );

   modport slave (
      output note_valid, note_x, note_y, note_colour,
      input  note_ready, x, y, colour, plot
   );
endinterface

// File: rtl/raster_counter.sv
// Walks a w x h rectangle from a latched origin, x fastest, one step per
// cycle; px/py are origin plus offset.
module raster_counter #(
   parameter int XW = 9,
   parameter int YW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step,
   input  logic [XW-1:0] x0,
   input  logic [YW-1:0] y0,
   input  logic [XW-1:0] w,
   input  logic [YW-1:0] h,
   output logic [XW-1:0] px,
   output logic [YW-1:0] py,
   output logic          last
);
   logic [XW-1:0] org_x, off_x;
   logic [YW-1:0] org_y, off_y;
   logic          row_end;

   assign row_end = (off_x == w - XW'(1));
   assign last    = row_end && (off_y == h - YW'(1));
   assign px      = org_x + off_x;
   assign py      = org_y + off_y;

   always_ff @(posedge clk) begin
      if (reset) begin
         org_x <= '0;
         org_y <= '0;
         off_x <= '0;
         off_y <= '0;
      end else if (load) begin
         org_x <= x0;
         org_y <= y0;
         off_x <= '0;
         off_y <= '0;
      end else if (step) begin
         if (row_end) begin
            off_x <= '0;
            off_y <= last ? '0 : off_y + YW'(1);
         end else begin
            off_x <= off_x + XW'(1);
         end
      end
   end
endmodule

// File: rtl/lane_frame_scheduler.sv
// Per-frame playfield regeneration: background raster sweep followed by
// note-rectangle overlays, streamed one pixel per cycle into vga_adapter.
module lane_frame_scheduler
   import game_vga_pkg::*;
#(
   parameter int H_RES       = H_RES_DEF,
   parameter int V_RES       = V_RES_DEF,
   parameter int FRAME_TICKS = 833333,
   parameter int NOTE_W      = 20,
   parameter int NOTE_H      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   output logic [X_W-1:0]         qx,
   output logic [Y_W-1:0]         qy,
   input  logic [COL_W-1:0]       bg_colour,
   lane_frame_scheduler_if.master bus,
   output logic                   frame_tick,
   output logic                   busy,
   output logic                   overrun
);
   localparam int               CNT_W    = $clog2(FRAME_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] frame_cnt;
   logic             sweep_load, sweep_step, sweep_last;
   logic             note_load, note_step, note_last;
   logic [X_W-1:0]   sweep_x;
   logic [Y_W-1:0]   sweep_y;
   logic [X_W:0]     note_px;
   logic [Y_W:0]     note_py;
   logic [COL_W-1:0] note_col_q;
   note_req_t        note_in;
   pix_t             pix_d, pix_q;

   assign note_in = '{x: bus.note_x, y: bus.note_y, colour: bus.note_colour};

   // Disabled means held at zero, so re-enabling always gives a full period.
   always_ff @(posedge clk) begin
      if (reset || !enable || frame_cnt == CNT_LAST)
         frame_cnt <= '0;
      else
         frame_cnt <= frame_cnt + CNT_W'(1);
   end

   assign frame_tick = enable && (frame_cnt == CNT_LAST);

   raster_counter #(.XW(X_W), .YW(Y_W)) u_sweep (
      .clk   (clk),
      .reset (reset),
      .load  (sweep_load),
      .step  (sweep_step),
      .x0    ('0),
      .y0    ('0),
      .w     (X_W'(H_RES)),
      .h     (Y_W'(V_RES)),
      .px    (sweep_x),
      .py    (sweep_y),
      .last  (sweep_last)
   );

   raster_counter #(.XW(X_W + 1), .YW(Y_W + 1)) u_note (
      .clk   (clk),
      .reset (reset),
      .load  (note_load),
      .step  (note_step),
      .x0    ({1'b0, note_in.x}),
      .y0    ({1'b0, note_in.y}),
      .w     ((X_W + 1)'(NOTE_W)),
      .h     ((Y_W + 1)'(NOTE_H)),
      .px    (note_px),
      .py    (note_py),
      .last  (note_last)
   );

   always_comb begin
      state_nxt  = state;
      sweep_load = 1'b0;
      sweep_step = 1'b0;
      note_load  = 1'b0;
      note_step  = 1'b0;
      case (state)
         IDLE: begin
            if (frame_tick) begin
               sweep_load = 1'b1;
               state_nxt  = SWEEP;
            end
         end
         SWEEP: begin
            sweep_step = 1'b1;
            if (sweep_last) state_nxt = NOTE_WAIT;
         end
         NOTE_WAIT: begin
            if (bus.note_valid) begin
               note_load = 1'b1;
               state_nxt = NOTE_DRAW;
            end else begin
               state_nxt = IDLE;
            end
         end
         NOTE_DRAW: begin
            note_step = 1'b1;
            if (note_last) state_nxt = NOTE_WAIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Clipped note pixels still spend their cycle, just without a write.
   always_comb begin
      pix_d = '0;
      if (sweep_step) begin
         pix_d.plot    = 1'b1;
         pix_d.from_bg = 1'b1;
         pix_d.x       = sweep_x;
         pix_d.y       = sweep_y;
      end else if (note_step && on_screen(note_px, note_py, H_RES, V_RES)) begin
         pix_d.plot   = 1'b1;
         pix_d.x      = note_px[X_W-1:0];
         pix_d.y      = note_py[Y_W-1:0];
         pix_d.colour = note_col_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         overrun    <= 1'b0;
         note_col_q <= BLACK;
         pix_q      <= '0;
      end else begin
         state <= state_nxt;
         pix_q <= pix_d;
         if (frame_tick && state != IDLE) overrun <= 1'b1;
         if (note_load) note_col_q <= note_in.colour;
      end
   end

   assign qx             = sweep_x;
   assign qy             = sweep_y;
   assign busy           = (state != IDLE);
   assign bus.note_ready = (state == NOTE_WAIT);
   assign bus.x          = pix_q.x;
   assign bus.y          = pix_q.y;
   assign bus.plot       = pix_q.plot;
   // Painter answers one cycle after the query, i.e. alongside the registered pixel.
   assign bus.colour     = pix_q.from_bg ? bg_colour : pix_q.colour;
endmodule

// File: tb/tb_lane_frame_scheduler.sv
// Bench for lane_frame_scheduler on a small 8x4 screen: scoreboarded pixel
// stream, table of note placements, overrun, reset and enable sequences.
module tb_lane_frame_scheduler;
   localparam int H = 8, V = 4, NW = 2, NH = 2;

   logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
   always #5 clk = ~clk;

   logic [8:0] qx_a, qx_o;
   logic [7:0] qy_a, qy_o;
   logic [2:0] bg_a = 3'b0, bg_o = 3'b0;
   logic       tick_a, busy_a, ovr_a, tick_o, busy_o, ovr_o;

   lane_frame_scheduler_if bus_a ();
   lane_frame_scheduler_if bus_o ();

   lane_frame_scheduler #(.H_RES(H), .V_RES(V), .FRAME_TICKS(100), .NOTE_W(NW), .NOTE_H(NH)) dut (
      .clk(clk), .reset(reset), .enable(enable), .qx(qx_a), .qy(qy_a), .bg_colour(bg_a),
      .bus(bus_a), .frame_tick(tick_a), .busy(busy_a), .overrun(ovr_a));

   lane_frame_scheduler #(.H_RES(H), .V_RES(V), .FRAME_TICKS(20), .NOTE_W(NW), .NOTE_H(NH)) dut_o (
      .clk(clk), .reset(reset), .enable(enable), .qx(qx_o), .qy(qy_o), .bg_colour(bg_o),
      .bus(bus_o), .frame_tick(tick_o), .busy(busy_o), .overrun(ovr_o));

   function automatic logic [2:0] paint(input logic [8:0] px, input logic [7:0] py);
      return px[2:0] ^ {py[1:0], 1'b1};
   endfunction

   // Registered painter: answers the previous cycle's query.
   always @(posedge clk) begin
      bg_a <= paint(qx_a, qy_a);
      bg_o <= paint(qx_o, qy_o);
   end

   typedef struct packed {logic [8:0] x; logic [7:0] y; logic [2:0] c;} exp_pix_t;
   typedef struct {logic [8:0] nx; logic [7:0] ny; logic [2:0] nc; int n_vis;} note_vec_t;

   exp_pix_t sb[$];
   exp_pix_t sb_exp;
   int n_cmp = 0, n_err = 0, cyc = 0;
   bit ov_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic release_reset();
      step();
      reset = 1'b0;
      cyc   = 0;
   endtask

   always @(negedge clk) begin
      if (bus_a.plot === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_plot", {bus_a.x, bus_a.y, bus_a.colour}, 32'hFFFF_FFFF);
         end else begin
            sb_exp = sb.pop_front();
            chk("sb_pixel", {bus_a.x, bus_a.y, bus_a.colour}, sb_exp);
         end
      end
   end

   // Second instance: 20-cycle frames against a 33-cycle busy period.
   always @(negedge clk) begin
      if (ov_on) begin
         case (cyc)
            38:  chk("ovr_before", ovr_o, 0);
            40: begin
               chk("ovr_set", ovr_o, 1);
               chk("ovr_pix_kept", {bus_o.plot, bus_o.x, bus_o.y}, {1'b1, 9'd3, 8'd2});
            end
            41:  chk("ovr_no_restart", {bus_o.x, bus_o.y}, {9'd4, 8'd2});
            150: chk("ovr_sticky", ovr_o, 1);
            default: ;
         endcase
      end
   end

   task automatic push_sweep();
      for (int yy = 0; yy < V; yy++)
         for (int xx = 0; xx < H; xx++)
            sb.push_back({9'(xx), 8'(yy), paint(9'(xx), 8'(yy))});
   endtask

   task automatic run_frame(input logic use_note, input note_vec_t v, input int exp_tick, output int t);
      int a, fall, hs, rdy, plots, sw, fp;
      logic rise, drop;
      t = -1; a = -1; fall = -1; hs = 0; rdy = 0; plots = 0; sw = 0; fp = -1;
      rise = 1'b0; drop = 1'b0;
      push_sweep();
      if (use_note)
         for (int j = 0; j < NH; j++)
            for (int i = 0; i < NW; i++)
               if (int'(v.nx) + i < H && int'(v.ny) + j < V)
                  sb.push_back({9'(int'(v.nx) + i), 8'(int'(v.ny) + j), v.nc});
      bus_a.note_x      = v.nx;
      bus_a.note_y      = v.ny;
      bus_a.note_colour = v.nc;
      bus_a.note_valid  = use_note;
      for (int k = 0; k < 400 && fall < 0; k++) begin
         step();
         if (drop) begin
            bus_a.note_valid = 1'b0;
            drop = 1'b0;
         end
         if (tick_a && t < 0) t = cyc;
         if (t >= 0 && cyc == t + 1) rise = busy_a;
         if (bus_a.plot) begin
            plots++;
            if (fp < 0) fp = cyc;
            if (t >= 0 && cyc >= t + 2 && cyc <= t + 33) sw++;
         end
         if (bus_a.note_ready) rdy++;
         if (bus_a.note_ready && bus_a.note_valid) begin
            hs++;
            a = cyc;
            drop = 1'b1;
         end
         if (t >= 0 && cyc > t + 1 && !busy_a) fall = cyc;
      end
      chk("tick_cycle", t, exp_tick);
      chk("busy_rise", rise, 1);
      chk("first_plot", fp, t + 2);
      chk("sweep_run", sw, 32);
      chk("plot_total", plots, 32 + (use_note ? v.n_vis : 0));
      chk("handshakes", hs, use_note ? 1 : 0);
      chk("ready_cycles", rdy, use_note ? 2 : 1);
      if (use_note) chk("accept_cycle", a, t + 33);
      chk("busy_fall", fall, use_note ? t + 39 : t + 34);
      chk("sb_drained", sb.size(), 0);
   endtask

   note_vec_t tbl[7];
   note_vec_t none;

   initial begin
      int t, nt, ticks, busys;
      tbl[0] = '{nx: 9'd2,   ny: 8'd1,   nc: 3'b010, n_vis: 4};
      tbl[1] = '{nx: 9'd7,   ny: 8'd3,   nc: 3'b101, n_vis: 1};
      tbl[2] = '{nx: 9'd6,   ny: 8'd2,   nc: 3'b110, n_vis: 4};
      tbl[3] = '{nx: 9'd7,   ny: 8'd0,   nc: 3'b011, n_vis: 2};
      tbl[4] = '{nx: 9'd0,   ny: 8'd3,   nc: 3'b100, n_vis: 2};
      tbl[5] = '{nx: 9'd9,   ny: 8'd1,   nc: 3'b111, n_vis: 0};
      tbl[6] = '{nx: 9'd511, ny: 8'd255, nc: 3'b001, n_vis: 0};
      none   = '{nx: 9'd0, ny: 8'd0, nc: 3'b000, n_vis: 0};
      bus_a.note_valid = 1'b0; bus_a.note_x = '0; bus_a.note_y = '0; bus_a.note_colour = '0;
      bus_o.note_valid = 1'b0; bus_o.note_x = '0; bus_o.note_y = '0; bus_o.note_colour = '0;

      repeat (3) step();
      chk("rst_bus_a", {bus_a.plot, bus_a.x, bus_a.y, bus_a.colour, bus_a.note_ready}, 0);
      chk("rst_flags_a", {tick_a, busy_a, ovr_a}, 0);
      chk("rst_query_a", {qx_a, qy_a}, 0);
      chk("rst_bus_o", {bus_o.plot, bus_o.x, bus_o.y, bus_o.colour, bus_o.note_ready}, 0);
      chk("rst_flags_o", {tick_o, busy_o, ovr_o}, 0);

      enable = 1'b1;
      ov_on  = 1'b1;
      release_reset();
      run_frame(1'b0, none, 99, t);
      for (int n = 0; n < 7; n++) begin
         run_frame(1'b1, tbl[n], t + 100, nt);
         t = nt;
      end
      ov_on = 1'b0;

      // Reset in the cycle that queries (3,2), the 20th sweep pixel.
      push_sweep();
      nt = -1;
      for (int k = 0; k < 200 && nt < 0; k++) begin
         step();
         if (tick_a) nt = cyc;
      end
      chk("rst_mid_tick_seen", nt >= 0, 1);
      repeat (20) step();
      chk("rst_mid_query", {qx_a, qy_a}, {9'd3, 8'd2});
      reset = 1'b1;
      step();
      chk("rst_mid_bus", {bus_a.plot, bus_a.x, bus_a.y, bus_a.colour, bus_a.note_ready}, 0);
      chk("rst_mid_flags", {busy_a, tick_a, ovr_a, ovr_o}, 0);
      chk("rst_mid_query0", {qx_a, qy_a}, 0);
      chk("rst_mid_left", sb.size(), 13);
      sb.delete();
      release_reset();
      run_frame(1'b0, none, 99, t);

      // Disabled counter: no ticks, never busy, then a full period once enabled.
      reset  = 1'b1;
      enable = 1'b0;
      step();
      release_reset();
      ticks = 0;
      busys = 0;
      for (int k = 0; k < 500; k++) begin
         step();
         if (tick_a || tick_o) ticks++;
         if (busy_a || busy_o) busys++;
      end
      chk("dis_ticks", ticks, 0);
      chk("dis_busy", busys, 0);
      enable = 1'b1;
      cyc    = 0;
      run_frame(1'b1, tbl[0], 99, t);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
